// File: rtl/penc8_arbiter_pkg.sv
// Shared definitions for the penc8 arbiter slice.
// Contents: arbiter FSM state encoding, requester count, owner-index width.
package penc8_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/penc8_arbiter_penc8.sv
// 8-to-3 priority encoder, highest set index wins.
// Ports:
//   vec   in  [7:0]  input vector
//   idx   out [2:0]  index of the highest set bit (0 when vec is zero)
//   valid out        vec is non-zero
module penc8_arbiter_penc8
    import penc8_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [ID_W-1:0]  idx,
    output logic             valid
);

    // Ascending scan: a later (higher) set bit overwrites earlier ones.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx   = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/penc8_arbiter.sv
// Single-resource arbiter for eight requesters with fixed (or optionally
// rotating) priority, hold-time limit and a one-cycle dead slot between grants.
// Optional feature macro: ARB_ROUND_ROBIN_EN (rotating priority in IDLE).
// Ports:
//   clk       in        system clock, rising edge
//   rst       in        synchronous active-high reset
//   req       in  [7:0] request vector
//   gnt       out [7:0] one-hot grant, zero with no owner
//   gnt_id    out [2:0] current owner index, zero with no owner
//   gnt_valid out       an owner holds the resource
//   timeout   out       one-cycle pulse when the hold limit forces a release
//
// state | meaning
// IDLE  | no owner, arbitrate the live req vector
// GRANT | owner holds the resource, hold counter running
// GAP   | one-cycle dead slot after a release
module penc8_arbiter
    import penc8_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [ID_W-1:0]  gnt_id_nxt;
    logic             gnt_valid_nxt;
    logic             timeout_nxt;

    logic [N_REQ-1:0] penc_in;
    logic [ID_W-1:0]  win_id;
    logic             win_valid;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]  last_owner;
    logic [N_REQ-1:0] masked;

    // Indices strictly below the last owner get first pick; if none are
    // requesting, fall back to the full vector so the search wraps to the top.
    assign masked  = req & ((N_REQ'(1) << last_owner) - N_REQ'(1));
    assign penc_in = (masked != '0) ? masked : req;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= '0;
        end else if (state == IDLE && win_valid) begin
            last_owner <= win_id;
        end
    end
`else
    assign penc_in = req;
`endif

    penc8_arbiter_penc8 u_penc (
        .vec   (penc_in),
        .idx   (win_id),
        .valid (win_valid)
    );

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_nxt     = GRANT;
                    gnt_nxt       = N_REQ'(1) << win_id;
                    gnt_id_nxt    = win_id;
                    gnt_valid_nxt = 1'b1;
                    cnt_nxt       = '0;
                end
            end
            GRANT: begin
                // A voluntary drop takes precedence over the hold limit.
                if (!req[gnt_id] || cnt == HOLD_LAST) begin
                    state_nxt     = GAP;
                    gnt_nxt       = '0;
                    gnt_id_nxt    = '0;
                    gnt_valid_nxt = 1'b0;
                    timeout_nxt   = req[gnt_id];
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                gnt_nxt       = '0;
                gnt_id_nxt    = '0;
                gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_penc8_arbiter.sv
module tb_penc8_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int tests = 0;
    int fails = 0;

    penc8_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                           input logic e_valid, input logic e_to);
        chk({tag, ".gnt"}, gnt, e_gnt);
        chk({tag, ".gnt_id"}, {5'd0, gnt_id}, {5'd0, e_id});
        chk({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, e_valid});
        chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e_to});
    endtask

    initial begin
        logic [2:0] exp_id;
        rst = 1'b1;
        req = 8'hFF;

        // Reset held with all requests active
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        req = 8'h00;
        step();
        chk_all("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

        // Fixed priority, then lower requester after the dead slot
        req = 8'b0010_0100;
        step();
        chk_all("prio_grant5", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
        step();
        chk_all("prio_hold5", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
        req = 8'b0000_0100;
        step();
        chk_all("prio_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_all("prio_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_all("prio_grant2", 8'b0000_0100, 3'd2, 1'b1, 1'b0);
        req = 8'h00;
        step();
        chk_all("prio_rel2", 8'h00, 3'd0, 1'b0, 1'b0);
        step();

        // Timeout: grant held exactly 4 cycles
        req = 8'b0000_1000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("to_hold3", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        end
        step();
        chk_all("to_pulse", 8'h00, 3'd0, 1'b0, 1'b1);
        step();
        chk_all("to_gap", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_all("to_regrant", 8'b0000_1000, 3'd3, 1'b1, 1'b0);

        // Drop exactly at the last hold cycle: no timeout
        step();
        step();
        step();
        chk_all("race_last", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        step();
        chk_all("race_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_all("race_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // No preemption by a higher index
        req = 8'b0000_0010;
        step();
        chk_all("nopre_grant1", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
        req = 8'b1000_0010;
        step();
        chk_all("nopre_hold1a", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
        step();
        chk_all("nopre_hold1b", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
        req = 8'b1000_0000;
        step();
        chk_all("nopre_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_all("nopre_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        chk_all("nopre_grant7", 8'b1000_0000, 3'd7, 1'b1, 1'b0);
        req = 8'h00;
        step();
        step();

        // Mid-grant reset
        req = 8'b0001_0000;
        step();
        chk_all("mrst_grant4", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        chk_all("mrst_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // All requesting: rotation or fixed winner
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_id = 3'(7 - (k % 8));
`else
            exp_id = 3'd7;
`endif
            step();
            chk_all("all_grant", 8'd1 << exp_id, exp_id, 1'b1, 1'b0);
            step();
            step();
            step();
            step();
            chk_all("all_timeout", 8'h00, 3'd0, 1'b0, 1'b1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
